// File: rtl/count_sequencer.sv
// Run/pause/stop sequencer for an NDIG-digit up/down BCD counter paced by an external timer.
// Optional SEG_DECODE_EN adds a registered 7-segment (gfedcba, active-high) decode port.
module count_sequencer #(
  parameter int unsigned      WIDTH         = 32,
  parameter int unsigned      NDIG          = 2,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(49_999_999)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              step,
  input  logic              dir,
  input  logic              period_ld,
  input  logic [WIDTH-1:0]  period_in,
  input  logic              tmr_pulse,
  output logic              tmr_rst,
  output logic [WIDTH-1:0]  tmr_limit,
  output logic [4*NDIG-1:0] bcd,
  output logic [1:0]        state,
  output logic              running,
  output logic              wrap
`ifdef SEG_DECODE_EN
  ,
  output logic [7*NDIG-1:0] seg
`endif
);

  localparam int unsigned BW = 4 * NDIG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] bcd_inc;
  logic [BW-1:0] bcd_dec;
  logic          inc_wrap;
  logic          dec_wrap;
  logic          step_ok;
  logic          advance;

  assign state   = state_q;
  // Timer is held in reset whenever it must restart from zero on the next RUN cycle.
  assign tmr_rst = (state_q != S_RUN) | clear | period_ld;

  // Only the highest-priority asserted command acts; step loses to any other command.
  assign step_ok = step & ~clear & ~stop & ~start & (state_q != S_RUN);
  assign advance = (tmr_pulse & (state_q == S_RUN) & ~clear) | step_ok;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
      end else if (state_q == S_PAUSE) begin
        state_d = S_IDLE;
      end
    end else if (start) begin
      state_d = S_RUN;
    end
  end

  // Ripple increment/decrement; a carry/borrow out of the top digit is the wrap.
  always_comb begin
    bcd_inc  = bcd;
    bcd_dec  = bcd;
    inc_wrap = 1'b1;
    dec_wrap = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (inc_wrap) begin
        if (bcd[4*i +: 4] >= 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          inc_wrap          = 1'b0;
        end
      end
      if (dec_wrap) begin
        if (bcd[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
          dec_wrap          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      running   <= 1'b0;
      bcd       <= '0;
      wrap      <= 1'b0;
      tmr_limit <= DEFAULT_LIMIT;
    end else begin
      state_q <= state_d;
      running <= (state_d == S_RUN);
      wrap    <= 1'b0;
      if (period_ld) begin
        tmr_limit <= period_in;
      end
      if (clear) begin
        bcd <= '0;
      end else if (advance) begin
        bcd  <= dir ? bcd_dec : bcd_inc;
        wrap <= dir ? dec_wrap : inc_wrap;
      end
    end
  end

`ifdef SEG_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Decode lags bcd by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {NDIG{7'h3F}};
    end else begin
      for (int i = 0; i < int'(NDIG); i++) begin
        seg[7*i +: 7] <= seg7(bcd[4*i +: 4]);
      end
    end
  end
`endif

endmodule
